lsu_mem_master: RTL and testbench

//  Load/store initiator for the core's data-memory bus (AR/R/AW/W/B channels plus len/load_unsign sideband).

---
 rtl/lsu_mem_master.sv | 188 ++++++++++++++++++
 tb/tb_lsu_mem_master.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_master.sv
// Single-outstanding load/store initiator toward the data-memory bus (AR/R/AW/W/B plus len/load_unsign).
// Optional `LSU_TIMEOUT_EN: forces an error response after TIMEOUT_CYCLES without rvalid/bvalid.
module lsu_mem_master #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_len,
  input  logic        req_unsign,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        arvalid,
  output logic [31:0] araddr,
  output logic        load_unsign,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic        rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic        awvalid,
  output logic [31:0] awaddr,
  input  logic        awready,
  output logic        wvalid,
  output logic [31:0] wdata,
  output logic [31:0] len,
  input  logic        wready,
  input  logic        bresp,
  input  logic        bvalid,
  output logic        bready
);
  typedef enum logic [2:0] {S_IDLE, S_RD, S_WR, S_WR_B, S_RESP} state_e;

  state_e      state_q, state_d;
  logic        req_ready_q, req_ready_d, resp_valid_q, resp_valid_d, resp_err_q, resp_err_d;
  logic [31:0] rdata_q, rdata_d, addr_q, addr_d, wdata_q, wdata_d, len_q, len_d;
  logic        uns_q, uns_d, arvalid_q, arvalid_d, rready_q, rready_d;
  logic        awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d, bseen_q, bseen_d;
  logic        req_ok, aw_fin, w_fin, b_done, tmo_hit;

  assign req_ok = (req_len == 32'd1) ||
                  (req_len == 32'd2 && !req_addr[0]) ||
                  (req_len == 32'd4 && req_addr[1:0] == 2'b00);
  assign aw_fin = !awvalid_q || awready;
  assign w_fin  = !wvalid_q || wready;
  assign b_done = (bvalid && bready_q) || bseen_q;

  // arready is tied high by the memory; bresp carries no information for this core
  logic unused_ok;
  assign unused_ok = &{1'b0, arready, bresp};

`ifdef LSU_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TMO_W-1:0] tmo_q;
  logic             busy;
  assign busy    = (state_q == S_RD) || (state_q == S_WR) || (state_q == S_WR_B);
  assign tmo_hit = busy && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge clk) begin
    if (reset || !busy || state_d != state_q) tmo_q <= '0;
    else                                      tmo_q <= tmo_q + 1'b1;
  end
`else
  localparam int UNUSED_TMO = TIMEOUT_CYCLES;
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (req_valid) state_d = !req_ok ? S_RESP : (req_wen ? S_WR : S_RD);
      S_RD:   if (rvalid || tmo_hit) state_d = S_RESP;
      S_WR:   if (aw_fin && w_fin) state_d = S_WR_B;
              else if (tmo_hit)    state_d = S_RESP;
      S_WR_B: if (b_done || tmo_hit) state_d = S_RESP;
      S_RESP: if (resp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready_d  = (state_d == S_IDLE);
    resp_valid_d = resp_valid_q;
    resp_err_d   = resp_err_q;
    rdata_d      = rdata_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    len_d        = len_q;
    uns_d        = uns_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    bready_d     = bready_q;
    bseen_d      = bseen_q;
    unique case (state_q)
      S_IDLE: if (req_valid) begin
        addr_d  = req_addr;
        wdata_d = req_wdata;
        len_d   = req_len;
        uns_d   = req_unsign;
        rdata_d = '0;
        bseen_d = 1'b0;
        if (!req_ok) begin
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
        end else if (req_wen) begin
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          bready_d  = 1'b1;
        end else begin
          arvalid_d = 1'b1;
          rready_d  = 1'b1;
        end
      end
      S_RD: if (state_d == S_RESP) begin
        arvalid_d    = 1'b0;
        rready_d     = 1'b0;
        resp_valid_d = 1'b1;
        resp_err_d   = !(rvalid && rresp);
        rdata_d      = (rvalid && rresp) ? rdata : '0;
      end
      S_WR: begin
        awvalid_d = !aw_fin;
        wvalid_d  = !w_fin;
        // a B beat can overtake the W handshake; remember it for WR_B
        if (bvalid && bready_q) bseen_d = 1'b1;
        if (state_d == S_RESP) begin
          awvalid_d    = 1'b0;
          wvalid_d     = 1'b0;
          bready_d     = 1'b0;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
        end
      end
      S_WR_B: if (state_d == S_RESP) begin
        bready_d     = 1'b0;
        resp_valid_d = 1'b1;
        resp_err_d   = !b_done;
      end
      S_RESP: if (resp_ready) begin
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        rdata_d      = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req_ready_q <= 1'b1; resp_valid_q <= 1'b0; resp_err_q <= 1'b0; rdata_q <= '0;
      addr_q <= '0; wdata_q <= '0; len_q <= '0; uns_q <= 1'b0;
      arvalid_q <= 1'b0; rready_q <= 1'b0; awvalid_q <= 1'b0; wvalid_q <= 1'b0;
      bready_q <= 1'b0; bseen_q <= 1'b0;
    end else begin
      req_ready_q <= req_ready_d; resp_valid_q <= resp_valid_d; resp_err_q <= resp_err_d; rdata_q <= rdata_d;
      addr_q <= addr_d; wdata_q <= wdata_d; len_q <= len_d; uns_q <= uns_d;
      arvalid_q <= arvalid_d; rready_q <= rready_d; awvalid_q <= awvalid_d; wvalid_q <= wvalid_d;
      bready_q <= bready_d; bseen_q <= bseen_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign resp_valid  = resp_valid_q;
  assign resp_err    = resp_err_q;
  assign resp_rdata  = rdata_q;
  assign arvalid     = arvalid_q;
  assign araddr      = addr_q;
  assign awaddr      = addr_q;
  assign load_unsign = uns_q;
  assign rready      = rready_q;
  assign awvalid     = awvalid_q;
  assign wvalid      = wvalid_q;
  assign wdata       = wdata_q;
  assign len         = len_q;
  assign bready      = bready_q;
endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master: bus responder, expected-response queue model, literal checks.
module tb_lsu_mem_master;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, req_valid, req_ready, req_wen, req_unsign, resp_valid, resp_ready, resp_err;
  logic [31:0] req_addr, req_wdata, req_len, resp_rdata;
  logic        arvalid, load_unsign, arready, rresp, rvalid, rready;
  logic [31:0] araddr, rdata, awaddr, wdata, len;
  logic        awvalid, awready, wvalid, wready, bresp, bvalid, bready;

  lsu_mem_master #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_len(req_len), .req_unsign(req_unsign),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .arvalid(arvalid), .araddr(araddr), .load_unsign(load_unsign), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awvalid(awvalid), .awaddr(awaddr), .awready(awready),
    .wvalid(wvalid), .wdata(wdata), .len(len), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready));

  int n_cmp = 0, n_bad = 0;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  logic [31:0] mem [int unsigned];
  logic [31:0] shm [int unsigned];

  function automatic logic [31:0] ext(input logic [31:0] word, input logic [31:0] a,
                                      input logic [31:0] ln, input logic u);
    logic [31:0] s;
    s = word >> (8 * a[1:0]);
    if (ln == 1) return u ? {24'b0, s[7:0]} : {{24{s[7]}}, s[7:0]};
    if (ln == 2) return u ? {16'b0, s[15:0]} : {{16{s[15]}}, s[15:0]};
    return s;
  endfunction

  // memory responder: reads answer two cycles after arvalid appears, writes via byte lanes
  logic        rd_en = 1'b1, rresp_cfg = 1'b1, bus_act = 1'b0;
  int          aw_wait = 0, wr_cnt = 0;
  initial begin
    logic        ar_seen, aw_done, w_done;
    logic [31:0] wa, wd, wl, w;
    ar_seen = 0; aw_done = 0; w_done = 0; wa = 0; wd = 0; wl = 0;
    rvalid = 0; rdata = 0; rresp = 0; awready = 0; wready = 0; bvalid = 0; bresp = 0; arready = 1;
    forever begin
      @(negedge clk);
      if (reset) begin ar_seen = 0; aw_done = 0; w_done = 0; end
      bus_act = bus_act | arvalid | awvalid | wvalid;
      if (rvalid) rvalid = 0;
      else if (arvalid && rready && rd_en) begin
        if (ar_seen) begin
          rvalid = 1; rresp = rresp_cfg; ar_seen = 0;
          rdata = ext(mem[araddr >> 2], araddr, len, load_unsign);
        end else ar_seen = 1;
      end else ar_seen = 0;
      if (bvalid) bvalid = 0;
      else if (aw_done && w_done && bready) begin
        w = mem[wa >> 2];
        for (int i = 0; i < int'(wl); i++) w[8 * (int'(wa[1:0]) + i) +: 8] = wd[8 * i +: 8];
        mem[wa >> 2] = w;
        wr_cnt++; bvalid = 1; bresp = 1; aw_done = 0; w_done = 0;
      end
      if (awvalid && !aw_done) begin
        if (aw_wait > 0) begin awready = 0; aw_wait--; end
        else begin awready = 1; aw_done = 1; wa = awaddr; wl = len; end
      end else awready = 0;
      if (wvalid && !w_done) begin wready = 1; w_done = 1; wd = wdata; end
      else wready = 0;
    end
  end

  typedef struct { logic [31:0] d; logic e; } exp_t;
  exp_t q[$];

  // compare process: sampled mid-low-phase, after stimulus settles and before the edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk); #3;
      if (!reset && resp_valid && resp_ready) begin
        if (q.size() == 0) check("resp_unexpected", {31'b0, resp_valid}, 32'd0);
        else begin
          e = q.pop_front();
          check("resp_rdata", resp_rdata, e.d);
          check("resp_err", {31'b0, resp_err}, {31'b0, e.e});
        end
      end
    end
  end

  // mode: 0 = no response expected, 1 = model response, 2 = forced error
  task automatic issue(input logic wen, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] ln, input logic u, input int mode);
    int t;
    exp_t e;
    logic bad;
    logic [31:0] m;
    t = 0;
    @(negedge clk);
    while (!req_ready && t < 50) begin @(negedge clk); t++; end
    if (!req_ready) check("req_ready_wait", {31'b0, req_ready}, 32'd1);
    bad = !(ln == 1 || (ln == 2 && !a[0]) || (ln == 4 && a[1:0] == 2'b00));
    e.d = 0; e.e = 0;
    if (mode == 2 || bad) e.e = 1;
    else if (wen) begin
      m = (ln == 4) ? 32'hFFFF_FFFF : (ln == 2) ? 32'h0000_FFFF : 32'h0000_00FF;
      shm[a >> 2] = (shm[a >> 2] & ~(m << (8 * a[1:0]))) | ((wd & m) << (8 * a[1:0]));
    end else if (!rresp_cfg) e.e = 1;
    else e.d = ext(shm[a >> 2], a, ln, u);
    if (mode != 0) q.push_back(e);
    req_wen = wen; req_addr = a; req_wdata = wd; req_len = ln; req_unsign = u; req_valid = 1;
    @(posedge clk); #1 req_valid = 0;
  endtask

  // counts low phases after the accept edge until resp_valid
  task automatic wait_resp(input int n0, output int n);
    n = n0;
    do begin @(negedge clk); n++; end while (!resp_valid && n < 60);
    if (!resp_valid) check("resp_wait_expired", {31'b0, resp_valid}, 32'd1);
  endtask

  initial begin
    int n, w0;
    reset = 1; req_valid = 0; req_wen = 0; req_addr = 0; req_wdata = 0; req_len = 0; req_unsign = 0;
    resp_ready = 1;
    mem[32'h2000_0004] = 32'hDEAD_BEEF; mem[32'h2000_0000] = 32'h80A1_B2C3; mem[32'h2000_0001] = 32'h5566_7788;
    shm = mem;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_valids", {26'b0, arvalid, rready, awvalid, wvalid, bready, resp_valid}, 32'd0);
    check("rst_araddr", araddr, 32'd0);
    reset = 0;

    // aligned word load, minimum latency
    issue(0, 32'h8000_0010, 0, 4, 0, 1);
    @(negedge clk);
    check("ld4_arvalid", {30'b0, arvalid, rready}, 32'd3);
    check("ld4_araddr", araddr, 32'h8000_0010);
    wait_resp(1, n);
    check("ld4_latency", n, 32'd3);
    check("ld4_rdata_lit", resp_rdata, 32'hDEAD_BEEF);
    @(negedge clk);
    check("ld4_req_ready_after", {31'b0, req_ready}, 32'd1);

    // signed byte load: sideband held until rvalid
    issue(0, 32'h8000_0003, 0, 1, 0, 1);
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      check("lb_araddr", araddr, 32'h8000_0003);
      check("lb_len", len, 32'd1);
      check("lb_unsign_arvalid", {30'b0, load_unsign, arvalid}, 32'd1);
    end
    wait_resp(2, n);
    check("lb_rdata_lit", resp_rdata, 32'hFFFF_FF80);

    // halfword store with awready one cycle late
    w0 = wr_cnt; aw_wait = 1;
    issue(1, 32'h8000_0006, 32'h0000_1234, 2, 0, 1);
    @(negedge clk); check("sh_c1_aw_w", {30'b0, awvalid, wvalid}, 32'd3);
    @(negedge clk); check("sh_c2_aw_w", {30'b0, awvalid, wvalid}, 32'd2);
    @(negedge clk); check("sh_c3_aw_w", {30'b0, awvalid, wvalid}, 32'd0);
    wait_resp(3, n);
    check("sh_latency", n, 32'd4);
    check("sh_single_write", wr_cnt - w0, 32'd1);
    check("sh_mem_lit", mem[32'h2000_0001], 32'h1234_7788);

    issue(0, 32'h8000_0006, 0, 2, 1, 1);
    wait_resp(0, n);
    check("lhu_rdata_lit", resp_rdata, 32'h0000_1234);
    issue(0, 32'h8000_0000, 0, 2, 0, 1);
    wait_resp(0, n);
    issue(1, 32'h8000_0010, 32'hCAFE_F00D, 4, 0, 1);
    wait_resp(0, n);
    check("sw_latency", n, 32'd3);
    issue(0, 32'h8000_0010, 0, 4, 1, 1);
    wait_resp(0, n);

    // misaligned and illegal length: no bus activity
    @(negedge clk); bus_act = 0;
    issue(0, 32'h8000_0002, 0, 4, 0, 1);
    wait_resp(0, n);
    check("mis_latency", n, 32'd1);
    check("mis_err_lit", {31'b0, resp_err}, 32'd1);
    issue(1, 32'h8000_0000, 32'h1, 3, 0, 1);
    wait_resp(0, n);
    check("len3_err_lit", {31'b0, resp_err}, 32'd1);
    @(negedge clk);
    check("bad_no_bus", {31'b0, bus_act}, 32'd0);

    // responder error
    rresp_cfg = 0;
    issue(0, 32'h8000_0010, 0, 4, 0, 1);
    wait_resp(0, n);
    @(negedge clk); rresp_cfg = 1;

    // response back-pressure
    resp_ready = 0;
    issue(0, 32'h8000_0010, 0, 4, 0, 1);
    wait_resp(0, n);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("stall_valid_ready", {30'b0, resp_valid, req_ready}, 32'd2);
      check("stall_rdata", resp_rdata, 32'hCAFE_F00D);
    end
    resp_ready = 1;

    // reset while in RD
    rd_en = 0;
    issue(0, 32'h8000_0010, 0, 4, 0, 0);
    @(negedge clk); check("rstrd_arvalid", {31'b0, arvalid}, 32'd1);
    reset = 1;
    @(negedge clk);
    check("rstrd_valids", {26'b0, arvalid, rready, awvalid, wvalid, bready, resp_valid}, 32'd0);
    check("rstrd_req_ready", {31'b0, req_ready}, 32'd1);
    check("rstrd_araddr", araddr, 32'd0);
    reset = 0; rd_en = 1;

`ifdef LSU_TIMEOUT_EN
    rd_en = 0;
    issue(0, 32'h8000_0010, 0, 4, 0, 2);
    wait_resp(0, n);
    check("tmo_latency", n, 32'd9);
    check("tmo_err_lit", {31'b0, resp_err}, 32'd1);
    @(negedge clk); rd_en = 1;
    issue(0, 32'h8000_0010, 0, 4, 0, 1);
    wait_resp(0, n);
`endif

    repeat (3) @(negedge clk);
    check("queue_drained", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end
endmodule
